// File: rtl/icosoc_ctrl_master.sv
// Bridges the CPU native memory port onto NUM_MODS per-module ctrl buses with one-hot strobes.
// A timeout guard answers with all-ones when the selected responder never raises done.
module icosoc_ctrl_master #(
    parameter int         NUM_MODS = 16,
    parameter logic [7:0] BASE_HI  = 8'h20,
    parameter int         TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    input  logic [3:0]               mem_wstrb,
    output logic                     mem_ready,
    output logic [31:0]              mem_rdata,
    output logic [NUM_MODS-1:0]      ctrl_wr,
    output logic [NUM_MODS-1:0]      ctrl_rd,
    output logic [7:0]               ctrl_addr,
    output logic [31:0]              ctrl_wdat,
    input  logic [32*NUM_MODS-1:0]   ctrl_rdat_all,
    input  logic [NUM_MODS-1:0]      ctrl_done_all,
    output logic                     err_timeout,
    output logic                     err_decode
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int IW = (NUM_MODS > 1) ? $clog2(NUM_MODS) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state;
    logic [IW-1:0]       sel;
    logic                is_wr;
    logic [TW-1:0]       timer;

    logic [7:0]          req_idx;
    logic                req_hit;
    logic                idx_ok;
    logic [NUM_MODS-1:0] req_onehot;
    logic                done_sel;
    logic [31:0]         rdat_sel;

    assign req_idx    = mem_addr[23:16];
    assign req_hit    = mem_valid && (mem_addr[31:24] == BASE_HI);
    assign idx_ok     = {24'd0, req_idx} < 32'(NUM_MODS);
    assign req_onehot = NUM_MODS'(1) << req_idx;
    assign done_sel   = ctrl_done_all[sel];

    always_comb begin
        rdat_sel = '0;
        for (int i = 0; i < NUM_MODS; i++) begin
            if (sel == IW'(i))
                rdat_sel = ctrl_rdat_all[32*i +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            sel         <= '0;
            is_wr       <= 1'b0;
            timer       <= '0;
            mem_ready   <= 1'b0;
            mem_rdata   <= '0;
            ctrl_wr     <= '0;
            ctrl_rd     <= '0;
            ctrl_addr   <= '0;
            ctrl_wdat   <= '0;
            err_timeout <= 1'b0;
            err_decode  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_ready <= 1'b0;
                    if (req_hit) begin
                        if (idx_ok) begin
                            ctrl_addr <= mem_addr[7:0];
                            ctrl_wdat <= mem_wdata;
                            sel       <= req_idx[IW-1:0];
                            is_wr     <= |mem_wstrb;
                            if (|mem_wstrb)
                                ctrl_wr <= req_onehot;
                            else
                                ctrl_rd <= req_onehot;
                            timer     <= '0;
                            state     <= ACCESS;
                        end else begin
                            err_decode <= 1'b1;
                            mem_rdata  <= '0;
                            mem_ready  <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // done wins over a timeout expiring on the same edge
                    if (done_sel) begin
                        ctrl_wr   <= '0;
                        ctrl_rd   <= '0;
                        mem_rdata <= is_wr ? 32'd0 : rdat_sel;
                        mem_ready <= 1'b1;
                        state     <= RESP;
                    end else if (TIMEOUT != 0 && timer == TLAST) begin
                        ctrl_wr     <= '0;
                        ctrl_rd     <= '0;
                        mem_rdata   <= 32'hFFFF_FFFF;
                        err_timeout <= 1'b1;
                        mem_ready   <= 1'b1;
                        state       <= RESP;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icosoc_ctrl_master.sv
// Bench for icosoc_ctrl_master: register-output responders, scoreboarded mem_rdata, directed access cases.
module tb_icosoc_ctrl_master;

    logic          clk = 1'b0;
    logic          resetn;
    logic          mem_valid;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic [3:0]    ctrl_wr;
    logic [3:0]    ctrl_rd;
    logic [7:0]    ctrl_addr;
    logic [31:0]   ctrl_wdat;
    logic [127:0]  ctrl_rdat_all;
    logic [3:0]    ctrl_done_all;
    logic          err_timeout;
    logic          err_decode;

    always #5 clk = ~clk;

    icosoc_ctrl_master #(
        .NUM_MODS (4),
        .BASE_HI  (8'h20),
        .TIMEOUT  (8)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .ctrl_wr       (ctrl_wr),
        .ctrl_rd       (ctrl_rd),
        .ctrl_addr     (ctrl_addr),
        .ctrl_wdat     (ctrl_wdat),
        .ctrl_rdat_all (ctrl_rdat_all),
        .ctrl_done_all (ctrl_done_all),
        .err_timeout   (err_timeout),
        .err_decode    (err_decode)
    );

    // responders: done one cycle after seeing a strobe, suppressed while done is high
    logic [31:0] rdat [4];
    logic [31:0] wr_got [4];
    int          act_cnt [4];
    logic [3:0]  rsp_done;
    logic [3:0]  silent;
    logic [3:0]  extra_done;

    assign ctrl_rdat_all = {rdat[3], rdat[2], rdat[1], rdat[0]};
    assign ctrl_done_all = rsp_done | extra_done;

    initial begin
        for (int i = 0; i < 4; i++) begin
            act_cnt[i] = 0;
            wr_got[i]  = '0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!resetn) begin
                rsp_done[i] <= 1'b0;
            end else if (rsp_done[i]) begin
                rsp_done[i] <= 1'b0;
            end else if ((ctrl_wr[i] || ctrl_rd[i]) && !silent[i]) begin
                rsp_done[i] <= 1'b1;
                act_cnt[i]  <= act_cnt[i] + 1;
                if (ctrl_wr[i])
                    wr_got[i] <= ctrl_wdat;
            end
        end
    end

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // monitor: strobe bookkeeping and scoreboard pop on every mem_ready
    int          strobe_cycles = 0;
    int          ready_cnt = 0;
    logic [3:0]  last_wr = '0;
    logic [3:0]  last_rd = '0;
    logic        bad_strobe = 1'b0;

    always @(negedge clk) begin
        if (ctrl_wr != 4'd0 || ctrl_rd != 4'd0) begin
            strobe_cycles++;
            last_wr = ctrl_wr;
            last_rd = ctrl_rd;
            if (!$onehot({ctrl_wr, ctrl_rd}))
                bad_strobe = 1'b1;
        end
        if (mem_ready) begin
            ready_cnt++;
            if (exp_q.size() == 0)
                check("unexpected_ready", 32'd1, 32'd0);
            else
                check("mem_rdata", mem_rdata, exp_q.pop_front());
        end
    end

    // CPU-like driver: valid held until the edge that samples mem_ready
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        lat = 0;
        while (!mem_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50)
            check("req_no_ready", 32'd0, 32'd1);
        @(posedge clk);
        #1 mem_valid = 1'b0;
    endtask

    int lat;
    int s0;
    int r0;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        mem_valid  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        silent     = '0;
        extra_done = '0;
        rdat[0] = 32'h0BAD_0000;
        rdat[1] = 32'hCAFE_0001;
        rdat[2] = 32'hDEAD_0002;
        rdat[3] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl_wr", 32'(ctrl_wr), 32'd0);
        check("rst_ctrl_rd", 32'(ctrl_rd), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        check("rst_err_decode", 32'(err_decode), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // read module 3
        s0 = strobe_cycles;
        exp_q.push_back(32'h1234_5678);
        do_req(32'h2003_0004, 32'd0, 4'b0000, lat);
        check("rd3_latency", 32'(lat), 32'd3);
        check("rd3_strobe_cycles", 32'(strobe_cycles - s0), 32'd2);
        check("rd3_ctrl_rd", 32'(last_rd), 32'b1000);
        check("rd3_ctrl_wr", 32'(last_wr), 32'd0);
        check("rd3_ctrl_addr", 32'(ctrl_addr), 32'h04);
        check("rd3_actions", 32'(act_cnt[3]), 32'd1);

        // write module 0
        s0 = strobe_cycles;
        exp_q.push_back(32'd0);
        do_req(32'h2000_0000, 32'hA5A5_0001, 4'b0001, lat);
        check("wr0_latency", 32'(lat), 32'd3);
        check("wr0_strobe_cycles", 32'(strobe_cycles - s0), 32'd2);
        check("wr0_ctrl_wr", 32'(last_wr), 32'b0001);
        check("wr0_ctrl_addr", 32'(ctrl_addr), 32'h00);
        check("wr0_ctrl_wdat", ctrl_wdat, 32'hA5A5_0001);
        check("wr0_actions", 32'(act_cnt[0]), 32'd1);
        check("wr0_data_seen", wr_got[0], 32'hA5A5_0001);

        // module 1 delayed, module 2 pulses done mid-access
        silent[1] = 1'b1;
        s0 = strobe_cycles;
        r0 = ready_cnt;
        exp_q.push_back(32'hCAFE_0001);
        fork
            do_req(32'h2001_0008, 32'd0, 4'b0000, lat);
            begin
                repeat (2) @(posedge clk);
                #1 extra_done = 4'b0100;
                @(posedge clk);
                #1 extra_done = 4'b0000;
                @(posedge clk);
                #1 silent[1] = 1'b0;
            end
        join
        check("foreign_latency", 32'(lat), 32'd6);
        check("foreign_strobe_cycles", 32'(strobe_cycles - s0), 32'd5);
        check("foreign_ctrl_rd", 32'(last_rd), 32'b0010);
        check("foreign_ready_count", 32'(ready_cnt - r0), 32'd1);
        check("foreign_err_timeout", 32'(err_timeout), 32'd0);
        check("foreign_actions", 32'(act_cnt[1]), 32'd1);

        // decode error
        s0 = strobe_cycles;
        exp_q.push_back(32'd0);
        do_req(32'h2007_0000, 32'd0, 4'b0000, lat);
        check("dec_latency", 32'(lat), 32'd1);
        check("dec_strobe_cycles", 32'(strobe_cycles - s0), 32'd0);
        check("dec_err_decode", 32'(err_decode), 32'd1);

        // silent responder times out
        silent[2] = 1'b1;
        s0 = strobe_cycles;
        exp_q.push_back(32'hFFFF_FFFF);
        do_req(32'h2002_0000, 32'd0, 4'b0000, lat);
        check("to_latency", 32'(lat), 32'd9);
        check("to_strobe_cycles", 32'(strobe_cycles - s0), 32'd8);
        check("to_err_timeout", 32'(err_timeout), 32'd1);
        check("to_actions", 32'(act_cnt[2]), 32'd0);

        // a good access leaves both error flags set
        exp_q.push_back(32'h0BAD_0000);
        do_req(32'h2000_0020, 32'd0, 4'b0000, lat);
        check("sticky_err_timeout", 32'(err_timeout), 32'd1);
        check("sticky_err_decode", 32'(err_decode), 32'd1);

        // address outside the IO region is ignored
        s0 = strobe_cycles;
        r0 = ready_cnt;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h1000_0000;
        mem_wstrb = 4'b0000;
        repeat (12) @(negedge clk);
        mem_valid = 1'b0;
        check("noio_ready_count", 32'(ready_cnt - r0), 32'd0);
        check("noio_strobe_cycles", 32'(strobe_cycles - s0), 32'd0);

        // reset in the middle of an access
        silent[0] = 1'b1;
        r0 = ready_cnt;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h2000_0010;
        mem_wstrb = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_strobe_before_reset", 32'(ctrl_rd), 32'b0001);
        resetn    = 1'b0;
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_ctrl_rd", 32'(ctrl_rd), 32'd0);
        check("mid_rst_ctrl_wr", 32'(ctrl_wr), 32'd0);
        check("mid_rst_ctrl_addr", 32'(ctrl_addr), 32'd0);
        check("mid_rst_ctrl_wdat", ctrl_wdat, 32'd0);
        check("mid_rst_mem_ready", 32'(mem_ready), 32'd0);
        check("mid_rst_mem_rdata", mem_rdata, 32'd0);
        check("mid_rst_err_timeout", 32'(err_timeout), 32'd0);
        check("mid_rst_err_decode", 32'(err_decode), 32'd0);
        @(negedge clk);
        resetn    = 1'b1;
        silent[0] = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_rst_no_ready", 32'(ready_cnt - r0), 32'd0);

        // next request after the aborted one completes normally
        exp_q.push_back(32'h1234_5678);
        do_req(32'h2003_0004, 32'd0, 4'b0000, lat);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_actions", 32'(act_cnt[3]), 32'd2);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("strobe_onehot", 32'(bad_strobe), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
